// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide path: operation codes driven by the
// control unit and the state encoding of the iterative unit.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Signed variants have op[0] clear, divides have op[1] set.
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/unidade_mult_div_datapath.sv
// Iterative magnitude datapath: one shift-add or restoring-divide step per
// clock, plus the combinational sign fix-up of the finished magnitude result.
module unidade_mult_div_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opA_i,
    input  logic [WIDTH-1:0] opB_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    op_e                 op_in;
    logic                sgn_in;
    logic                a_neg;
    logic                b_neg;
    logic [WIDTH-1:0]    abs_a;
    logic [WIDTH-1:0]    abs_b;

    logic                is_div_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic                div0_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]    opnd_q;

    logic [WIDTH:0]      madd;
    logic [2*WIDTH-1:0]  mult_next;
    logic [WIDTH:0]      partial;
    logic                ge;
    logic [WIDTH-1:0]    rem_new;
    logic [2*WIDTH-1:0]  div_next;

    logic                neg_res;
    logic [2*WIDTH-1:0]  prod_fixed;
    logic [WIDTH-1:0]    quo;
    logic [WIDTH-1:0]    rem;

    assign op_in  = op_e'(op_i);
    assign sgn_in = op_is_signed(op_in);
    assign a_neg  = sgn_in & opA_i[WIDTH-1];
    assign b_neg  = sgn_in & opB_i[WIDTH-1];
    assign abs_a  = a_neg ? -opA_i : opA_i;
    assign abs_b  = b_neg ? -opB_i : opB_i;

    // Multiply: multiplier sits in the low half and is consumed LSB first while
    // the partial product grows in the high half (with carry) and shifts right.
    assign madd      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mult_next = {madd, acc_q[WIDTH-1:1]};

    // Divide: high half is the remainder, low half shifts dividend bits out and
    // quotient bits in. The remainder is always below the divisor, so the
    // difference fits back into WIDTH bits.
    assign partial  = acc_q[2*WIDTH-1:WIDTH-1];
    assign ge       = (partial >= {1'b0, opnd_q});
    assign rem_new  = ge ? (partial[WIDTH-1:0] - opnd_q) : partial[WIDTH-1:0];
    assign div_next = {rem_new, acc_q[WIDTH-2:0], ge};

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
        end else if (load_i) begin
            is_div_q <= op_is_div(op_in);
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            div0_q   <= (opB_i == '0);
            acc_q    <= {{WIDTH{1'b0}}, abs_a};
            opnd_q   <= abs_b;
        end else if (step_i) begin
            acc_q <= is_div_q ? div_next : mult_next;
        end
    end

    assign neg_res    = sign_a_q ^ sign_b_q;
    assign prod_fixed = neg_res ? -acc_q : acc_q;
    assign quo        = acc_q[WIDTH-1:0];
    assign rem        = acc_q[2*WIDTH-1:WIDTH];

    // A zero divisor leaves the dividend magnitude as remainder, so only the
    // quotient needs forcing; the remainder sign fix restores the raw opA.
    always_comb begin
        res_hi_o = prod_fixed[2*WIDTH-1:WIDTH];
        res_lo_o = prod_fixed[WIDTH-1:0];
        if (is_div_q) begin
            res_hi_o = sign_a_q ? -rem : rem;
            if (div0_q) begin
                res_lo_o = '1;
            end else begin
                res_lo_o = neg_res ? -quo : quo;
            end
        end
    end

endmodule

// File: rtl/unidade_mult_div.sv
// Multiply/divide unit beside the ALU: owns the control FSM, iteration counter
// and the architectural HI/LO registers; arithmetic lives in the datapath.
module unidade_mult_div
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               load;
    logic               step;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign load = (state_q == IDLE) && start;
    assign step = (state_q == CALC);

    unidade_mult_div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk      (clk),
        .reset_i  (reset),
        .load_i   (load),
        .step_i   (step),
        .op_i     (op),
        .opA_i    (opA),
        .opB_i    (opB),
        .res_hi_o (res_hi),
        .res_lo_o (res_lo)
    );

    // hi/lo are only written in IDLE (moves) or FIX, so MFHI/MFLO see the old
    // values for the whole of CALC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        if (mthi) hi_q <= opA;
                        if (mtlo) lo_q <= opA;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Directed bench for the multiply/divide unit: hand-computed HI/LO results,
// latency, move handling, ignored requests while busy and mid-operation reset.
module tb_unidade_mult_div;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unidade_mult_div #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .opA   (opA),
        .opB   (opB),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accept at edge N; operands are scrambled afterwards to prove they were latched.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; opA = a; opB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opA = $urandom; opB = $urandom;
        chk("busy_after_accept", {63'b0, busy}, 64'd1);
    endtask

    // 'already' = negedges since edge N that the caller has already consumed.
    task automatic wait_done(input string tag, input int already,
                             input logic [31:0] eh, input logic [31:0] el);
        int cycles;
        int drops;
        cycles = already;
        drops  = 0;
        while (!done && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (!done && !busy) drops++;
        end
        chk({tag, "_latency"}, 64'(cycles), 64'd33);
        chk({tag, "_busy_gap"}, 64'(drops), 64'd0);
        chk({tag, "_busy_at_done"}, {63'b0, busy}, 64'd0);
        chk({tag, "_hi"}, {32'b0, hi}, {32'b0, eh});
        chk({tag, "_lo"}, {32'b0, lo}, {32'b0, el});
        $display("txn %s: hi=%h lo=%h cycles=%0d", tag, hi, lo, cycles);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0; mthi = 1'b0; mtlo = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", {63'b0, busy}, 64'd0);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 0, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_minmin", 0, 32'h4000_0000, 32'h0000_0000);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done("divu", 0, 32'd2, 32'd14);
        issue(OP_DIV, 32'h0000_1234, 32'd0);
        wait_done("div_by0", 0, 32'h0000_1234, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        wait_done("div_neg_by0", 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        issue(OP_DIVU, 32'h0000_0055, 32'd0);
        wait_done("divu_by0", 0, 32'h0000_0055, 32'hFFFF_FFFF);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 0, 32'h0000_0000, 32'h8000_0000);

        // Moves in IDLE
        @(negedge clk); mthi = 1'b1; opA = 32'hAAAA_0000;
        @(negedge clk); mthi = 1'b0;
        chk("mthi_hi", {32'b0, hi}, 64'h0000_0000_AAAA_0000);
        chk("mthi_lo_kept", {32'b0, lo}, 64'h0000_0000_8000_0000);
        @(negedge clk); mtlo = 1'b1; opA = 32'h1234_5678;
        @(negedge clk); mtlo = 1'b0;
        chk("mtlo_lo", {32'b0, lo}, 64'h0000_0000_1234_5678);
        chk("mtlo_hi_kept", {32'b0, hi}, 64'h0000_0000_AAAA_0000);
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; opA = 32'h0F0F_0F0F;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        chk("mtboth_hi", {32'b0, hi}, 64'h0000_0000_0F0F_0F0F);
        chk("mtboth_lo", {32'b0, lo}, 64'h0000_0000_0F0F_0F0F);

        // start together with mthi: the move is dropped
        @(negedge clk); op = OP_DIVU; opA = 32'd100; opB = 32'd7; start = 1'b1; mthi = 1'b1;
        @(negedge clk); start = 1'b0; mthi = 1'b0;
        chk("start_mthi_busy", {63'b0, busy}, 64'd1);
        chk("start_mthi_hi_kept", {32'b0, hi}, 64'h0000_0000_0F0F_0F0F);
        wait_done("divu_vs_mthi", 0, 32'd2, 32'd14);

        // second start and moves during CALC are ignored
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd3);
        repeat (5) @(negedge clk);
        start = 1'b1; op = OP_DIV; opA = 32'd9; opB = 32'd3; mtlo = 1'b1; mthi = 1'b1;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
        chk("calc_hi_stable", {32'b0, hi}, 64'd2);
        chk("calc_lo_stable", {32'b0, lo}, 64'd14);
        wait_done("multu_ignored", 6, 32'h0000_0002, 32'hFFFF_FFFD);
        chk("no_queued_op", {63'b0, busy}, 64'd0);

        // asynchronous reset in the middle of a MULT
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_hi", {32'b0, hi}, 64'd0);
        chk("midrst_lo", {32'b0, lo}, 64'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("postrst_idle", {62'b0, busy, done}, 64'd0);
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_done("multu_after_rst", 0, 32'h0000_0001, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_mult_div.md
Name: unidade_mult_div

Overview:
Iterative multiply/divide unit that consumes the two register-file read operands (readData1/readData2) and produces the architectural HI/LO pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits directly downstream of the register bank in the execute stage, beside the ALU. The control unit stalls the core while busy is high; MFHI/MFLO read hi/lo combinationally from this block's outputs.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
opA  input  WIDTH  rs operand (readData1)
opB  input  WIDTH  rt operand (readData2)
mthi  input  1  write opA into HI
mtlo  input  1  write opA into LO
busy  output  1  operation in progress; core must stall
done  output  1  one-cycle pulse; hi/lo hold the new result
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset is asynchronous and active-high; clock is clk. On reset: state=IDLE; busy=0, done=0, hi=0, lo=0; internal registers cleared. Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- FSM states: IDLE, CALC, FIX.
- IDLE: done=0 except for the cycle immediately after FIX. If start is high at edge N: latch op; latch |opA| and |opB| (absolute values for signed ops, raw values for unsigned ops); latch the sign flags; clear the counter; go to CALC. busy=1 from edge N.
- CALC runs 32 edges, N+1..N+32, with the counter 0..31.
  - Multiply: shift-add on a 64-bit accumulator, one bit per edge.
  - Divide: restoring, one quotient bit per edge.
  - After count=31, go to FIX.
- FIX, edge N+33:
  - Signed multiply: negate the 64-bit product if signA^signB.
  - Signed divide: negate the quotient if signA^signB; negate the remainder if signA.
  - Write hi/lo, set done=1, busy=0, return to IDLE.
  - Total latency: done is high for exactly the cycle after edge N+33.
- Result mapping:
  - MULT/MULTU: hi = product[63:32], lo = product[31:0].
  - DIV/DIVU: lo = quotient, hi = remainder.
- Divide by zero (opB=0), both DIV and DIVU: lo = all ones, hi = opA. The full 33-cycle latency still applies.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0. This falls out of the absolute-value datapath; no special case is needed.
- start while busy: ignored, with no queuing. The operands must be held stable only at the accepting edge.
- mthi/mtlo while IDLE: hi or lo <= opA at that edge. Both may assert together; both registers take opA.
- mthi/mtlo while busy: ignored.
- start together with mthi/mtlo in IDLE: start wins and the move is dropped.
- hi/lo change only at FIX, on mthi/mtlo, or on reset. They are stable during CALC, so MFHI of the old value is legal until done.
- Accumulator widths: 64-bit product register; 33-bit partial remainder for the divide subtraction.

Decomposition:
- Shared package (mips_pkg): the op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU and the state encodings IDLE, CALC, FIX. The same package is used by the control unit that drives op.
- One natural sub-module, unidade_mult_div_datapath. It holds the iterative shift-add/restoring-divide step and the sign fix-up. The top level keeps the FSM, the counter and the hi/lo registers.

Test Plan:
- MULTU, opA=0xFFFFFFFF, opB=0xFFFFFFFF -> done one cycle after edge N+33; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT, opA=0xFFFFFFFD (-3), opB=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV, opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU, opA=100, opB=7 -> lo=14, hi=2.
- DIV with opB=0, opA=0x1234 -> lo=0xFFFFFFFF, hi=0x1234. DIV, opA=0x80000000, opB=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi with opA=0xAAAA0000 in IDLE -> hi=0xAAAA0000 next edge. A second start and an mtlo issued during CALC -> both ignored; the first result is unaffected.
- Assert reset at cycle 10 of a MULT -> busy, done, hi and lo all 0 immediately. A new start after reset deasserts completes correctly.
